sm_gpio_in: RTL and testbench
=============================

Name: sm_gpio_in

Overview:
Bus-attached input conditioning stage sitting upstream of the GPIO input path of the bus matrix.
- Synchronises and debounces raw pin inputs (buttons, switches).
- Presents filtered levels and sticky rise/fall edge flags as CPU-readable registers.
- Produces an interrupt-request line from the masked edge flags.
- Replaces direct wiring of raw pins to the matrix GPIO input.

Parameters:
WIDTH, 16, number of input bits; must be 1..32.
STABLE, 4, consecutive cycles a synchronised input must differ from the filtered level before the level toggles; must be >= 1.
CNT_W, 16, debounce counter width; must satisfy 2^CNT_W > STABLE.

Ports:
clk  in  1  system clock (CPU clock domain).
rst  in  1  reset.
pin  in  WIDTH  raw asynchronous pin inputs.
sel  in  1  register block selected by bus decode.
bAddr  in  32  bus byte address; only bAddr[3:2] decoded.
bWe  in  1  bus write enable; effective only when sel=1.
bWData  in  32  bus write data.
bRData  out  32  bus read data.
level  out  WIDTH  filtered input levels, for the matrix GpioInput.
irq  out  1  interrupt request.

Interface (already decided): one clock, clk; reset rst is synchronous and active-high.

Behaviour:
- Reset, sampled on a clk rising edge with rst=1, clears all state to 0: sync flops, counters, level, RISE, FALL, IRQ_EN.
- Consequently irq=0 and bRData reads 0 for every offset after reset.
- Synchroniser: two flops per bit, pin -> s1 -> s; s is pin delayed by 2 clocks.
- Debounce, per bit, every cycle:
  - if s == level: counter <= 0.
  - else if counter == STABLE-1: level <= s and counter <= 0; set RISE[i] if s=1, else set FALL[i].
  - else: counter <= counter+1.
- Latency: a clean pin change appears on level exactly STABLE+2 clocks later.
- A pulse shorter than STABLE synchronised cycles causes no level change and no flag.
- Bits are independent.
- Register map (word offset = bAddr[3:2]):
  - 0 LEVEL: RO, zero-extended level.
  - 1 RISE: sticky, write-1-to-clear.
  - 2 FALL: sticky, write-1-to-clear.
  - 3 IRQ_EN: RW, low WIDTH bits.
- Writes to LEVEL are ignored. Bits of bWData above WIDTH are ignored.
- bRData is combinational from bAddr[3:2] regardless of sel; the matrix gates it. This gives zero-wait reads for the single-cycle CPU.
- Write takes effect on the clk edge where sel=1 and bWe=1.
- Simultaneous edge detection and W1C of the same flag bit: set wins, flag stays 1.
- irq = |((RISE | FALL) & IRQ_EN), combinational from registers.
- Reset asserted mid-count discards the partial count.
- A pin held high through reset produces a RISE flag STABLE+2 cycles after reset release; this is intended behaviour.
- Counter never exceeds STABLE-1, so no wrap-around.

Decomposition:
- Shared config header holds the register offset constants (LEVEL=0, RISE=1, FALL=2, IRQ_EN=3).
- One sub-module, sm_gpio_in_bit: 2-flop sync, debounce counter, level flop, rise/fall pulse outputs.
- Instantiate sm_gpio_in_bit WIDTH times via generate.
- Top holds the flag registers, IRQ_EN register, read mux and irq.

Test Plan:
- Reset values: assert rst 3 cycles, pin=16'hFFFF -> level=0, irq=0, all four offsets read 0 while rst=1.
- Clean edge: STABLE=4, pin[0] 0->1 at cycle 0 -> level[0]=1 at cycle 6, RISE=32'h1, FALL=0.
- Glitch rejection: pin[3] high for 3 cycles then low -> level[3] stays 0, RISE reads 0.
- W1C: RISE=32'h5, write 32'h4 to offset 1 -> RISE=32'h1; write to offset 0 -> LEVEL unchanged.
- Set-vs-clear collision: W1C of RISE[2] on the same cycle bit 2's level rises -> RISE[2]=1 afterwards.
- Interrupt: IRQ_EN=32'h2, FALL[1] set -> irq=1; clear FALL[1] -> irq=0 next cycle. RISE[0] set with IRQ_EN[0]=0 -> irq stays 0.

Source files
------------

// File: rtl/sm_gpio_in_pkg.sv
// Shared definitions for the GPIO input conditioning block: register word offsets
// within the 16-byte register window.
package sm_gpio_in_pkg;

  typedef logic [1:0] reg_off_t;

  localparam reg_off_t REG_LEVEL  = 2'd0;
  localparam reg_off_t REG_RISE   = 2'd1;
  localparam reg_off_t REG_FALL   = 2'd2;
  localparam reg_off_t REG_IRQ_EN = 2'd3;

endpackage

// File: rtl/sm_gpio_in_bit.sv
// One conditioned input bit: two-flop synchroniser, debounce counter and filtered level.
// rise/fall pulse in the cycle before the edge on which the level toggles.
module sm_gpio_in_bit #(
  parameter int STABLE = 4,
  parameter int CNT_W  = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic pin,
  output logic level,
  output logic rise,
  output logic fall
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE - 1);

  logic             s1_q, s1_d;
  logic             s_q, s_d;
  logic             level_q, level_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    s1_d    = pin;
    s_d     = s1_q;
    level_d = level_q;
    cnt_d   = cnt_q;
    rise    = 1'b0;
    fall    = 1'b0;
    if (s_q == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_MAX) begin
      level_d = s_q;
      cnt_d   = '0;
      rise    = s_q;
      fall    = ~s_q;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q    <= 1'b0;
      s_q     <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      s1_q    <= s1_d;
      s_q     <= s_d;
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level = level_q;

endmodule

// File: rtl/sm_gpio_in.sv
// Debounced GPIO input block with sticky edge flags, W1C clearing, interrupt enable
// and a zero-wait combinational read port.
module sm_gpio_in
  import sm_gpio_in_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int STABLE = 4,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] pin,
  input  logic             sel,
  input  logic [31:0]      bAddr,
  input  logic             bWe,
  input  logic [31:0]      bWData,
  output logic [31:0]      bRData,
  output logic [WIDTH-1:0] level,
  output logic             irq
);

  logic [WIDTH-1:0] bit_level;
  logic [WIDTH-1:0] rise_set, fall_set;
  logic [WIDTH-1:0] rise_q, rise_d;
  logic [WIDTH-1:0] fall_q, fall_d;
  logic [WIDTH-1:0] irq_en_q, irq_en_d;
  logic [WIDTH-1:0] wr_bits;
  reg_off_t         off;
  logic             wr_en;
  logic             unused_bits;

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
    sm_gpio_in_bit #(
      .STABLE(STABLE),
      .CNT_W (CNT_W)
    ) u_bit (
      .clk  (clk),
      .rst  (rst),
      .pin  (pin[gi]),
      .level(bit_level[gi]),
      .rise (rise_set[gi]),
      .fall (fall_set[gi])
    );
  end

  assign off     = bAddr[3:2];
  assign wr_en   = sel & bWe;
  assign wr_bits = bWData[WIDTH-1:0];

  // A new edge in the same cycle as its W1C keeps the flag set.
  always_comb begin
    rise_d   = rise_q | rise_set;
    fall_d   = fall_q | fall_set;
    irq_en_d = irq_en_q;
    if (wr_en) begin
      case (off)
        REG_RISE:   rise_d   = (rise_q & ~wr_bits) | rise_set;
        REG_FALL:   fall_d   = (fall_q & ~wr_bits) | fall_set;
        REG_IRQ_EN: irq_en_d = wr_bits;
        default:    ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rise_q   <= '0;
      fall_q   <= '0;
      irq_en_q <= '0;
    end else begin
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      irq_en_q <= irq_en_d;
    end
  end

  always_comb begin
    bRData = '0;
    case (off)
      REG_LEVEL:  bRData[WIDTH-1:0] = bit_level;
      REG_RISE:   bRData[WIDTH-1:0] = rise_q;
      REG_FALL:   bRData[WIDTH-1:0] = fall_q;
      default:    bRData[WIDTH-1:0] = irq_en_q;
    endcase
  end

  assign level = bit_level;
  assign irq   = |((rise_q | fall_q) & irq_en_q);

  assign unused_bits = ^{bAddr[31:4], bAddr[1:0], bWData};

endmodule

// File: tb/tb_sm_gpio_in.sv
// Directed bench for sm_gpio_in: stimulus queues expected values, a negedge monitor
// pops and compares them whenever an observation is presented.
module tb_sm_gpio_in;

  localparam int WIDTH = 16;

  typedef struct {
    int          kind;   // 0: bRData, 1: level, 2: irq
    logic [31:0] val;
    string       name;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst;
  logic [WIDTH-1:0] pin;
  logic             sel;
  logic [31:0]      bAddr;
  logic             bWe;
  logic [31:0]      bWData;
  logic [31:0]      bRData;
  logic [WIDTH-1:0] level;
  logic             irq;

  exp_t        exp_q[$];
  exp_t        cur;
  logic [31:0] act;
  logic        obs_valid  = 1'b0;
  logic        finish_req = 1'b0;
  int          checks     = 0;
  int          failures   = 0;

  sm_gpio_in #(.WIDTH(WIDTH), .STABLE(4), .CNT_W(16)) dut (
    .clk   (clk),
    .rst   (rst),
    .pin   (pin),
    .sel   (sel),
    .bAddr (bAddr),
    .bWe   (bWe),
    .bWData(bWData),
    .bRData(bRData),
    .level (level),
    .irq   (irq)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic chk(input int kind, input logic [1:0] off, input logic [31:0] val,
                     input string name);
    exp_t e;
    e.kind = kind;
    e.val  = val;
    e.name = name;
    exp_q.push_back(e);
    bAddr     = {28'd0, off, 2'b00};
    obs_valid = 1'b1;
    cyc();
    obs_valid = 1'b0;
  endtask

  task automatic wr(input logic [1:0] off, input logic [31:0] d, input logic s);
    bAddr  = {28'd0, off, 2'b00};
    bWData = d;
    sel    = s;
    bWe    = 1'b1;
    cyc();
    sel    = 1'b0;
    bWe    = 1'b0;
    bWData = '0;
    $display("write off=%0d data=%08h sel=%0b", off, d, s);
  endtask

  always @(negedge clk) begin
    if (obs_valid) begin
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_obs: observation with empty queue");
      end else begin
        cur = exp_q.pop_front();
        case (cur.kind)
          0:       act = bRData;
          1:       act = 32'(level);
          default: act = {31'd0, irq};
        endcase
        checks++;
        if (act !== cur.val) begin
          failures++;
          $display("FAIL %s: got %08h want %08h", cur.name, act, cur.val);
        end else begin
          $display("check %s: got %08h ok", cur.name, act);
        end
      end
    end
    if (finish_req) begin
      checks++;
      if (exp_q.size() != 0) begin
        failures++;
        $display("FAIL queue_drain: got %0d pending want 0", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; pin = '1; sel = 1'b0; bAddr = '0; bWe = 1'b0; bWData = '0;
    cycles(3);
    chk(1, 2'd0, 32'h0, "rst_level");
    chk(2, 2'd0, 32'h0, "rst_irq");
    chk(0, 2'd0, 32'h0, "rst_rd_level");
    chk(0, 2'd1, 32'h0, "rst_rd_rise");
    chk(0, 2'd2, 32'h0, "rst_rd_fall");
    chk(0, 2'd3, 32'h0, "rst_rd_irq_en");
    pin = '0;
    cycles(3);
    rst = 1'b0;

    // clean rising edge on bit 0: level appears 6 clocks later
    pin[0] = 1'b1;
    cycles(5);
    chk(1, 2'd0, 32'h0, "edge_lat5");
    chk(1, 2'd0, 32'h1, "edge_lat6");
    chk(0, 2'd1, 32'h1, "edge_rise");
    chk(0, 2'd2, 32'h0, "edge_fall");

    // 3-cycle glitch on bit 3
    pin[3] = 1'b1;
    cycles(3);
    pin[3] = 1'b0;
    cycles(10);
    chk(1, 2'd0, 32'h1, "glitch_level");
    chk(0, 2'd1, 32'h1, "glitch_rise");

    pin[2] = 1'b1;
    cycles(8);
    chk(0, 2'd1, 32'h5, "rise_5");
    chk(1, 2'd0, 32'h5, "level_5");
    chk(0, 2'd2, 32'h0, "fall_0");

    wr(2'd1, 32'h4, 1'b1);
    chk(0, 2'd1, 32'h1, "w1c_rise");
    wr(2'd1, 32'h1, 1'b0);
    chk(0, 2'd1, 32'h1, "w1c_nosel");
    wr(2'd0, 32'hFFFF_FFFF, 1'b1);
    chk(0, 2'd0, 32'h5, "level_ro");

    // collision: W1C of RISE[2] on the edge its level rises
    pin[2] = 1'b0;
    cycles(8);
    chk(0, 2'd2, 32'h4, "fall_bit2");
    chk(1, 2'd0, 32'h1, "level_bit2_low");
    pin[2] = 1'b1;
    cycles(5);
    wr(2'd1, 32'h4, 1'b1);
    chk(0, 2'd1, 32'h5, "collide_rise");
    chk(1, 2'd0, 32'h5, "collide_level");

    // interrupt masking
    wr(2'd3, 32'hFFFF_0002, 1'b1);
    chk(0, 2'd3, 32'h2, "irq_en_rd");
    chk(2, 2'd0, 32'h0, "irq_masked");
    pin[1] = 1'b1;
    cycles(8);
    wr(2'd1, 32'h2, 1'b1);
    chk(0, 2'd1, 32'h5, "rise_clr_b1");
    pin[1] = 1'b0;
    cycles(8);
    chk(0, 2'd2, 32'h6, "fall_b1");
    chk(2, 2'd0, 32'h1, "irq_fall1");
    wr(2'd2, 32'h2, 1'b1);
    chk(2, 2'd0, 32'h0, "irq_cleared");
    chk(0, 2'd2, 32'h4, "fall_after_clr");
    wr(2'd3, 32'h1, 1'b1);
    chk(2, 2'd0, 32'h1, "irq_rise0");

    // reset mid-count with pins held high
    pin[4] = 1'b1;
    cycles(4);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk(0, 2'd1, 32'h0, "rst2_rise");
    chk(2, 2'd0, 32'h0, "rst2_irq");
    cycles(3);
    chk(1, 2'd0, 32'h0, "rst2_lat5");
    chk(1, 2'd0, 32'h15, "rst2_lat6");
    chk(0, 2'd1, 32'h15, "rst2_rise_after");
    chk(0, 2'd3, 32'h0, "rst2_irq_en");

    finish_req = 1'b1;
    cycles(10);
    $display("FAIL finish: monitor did not end the run");
    $fatal(1, "no finish");
  end

endmodule
